// File: rtl/vga_pkg.sv
// Shared types and the built-in timing preset table for the VGA timing generator.
package vga_pkg;

    localparam int PW = 16;

    typedef struct packed {
        logic [PW-1:0] ha, hfp, hs, hbp;
        logic [PW-1:0] va, vfp, vs, vbp;
        logic          hpol, vpol;
    } vga_preset_t;

    function automatic vga_preset_t make_preset(input int ha, input int hfp, input int hs, input int hbp,
                                                input int va, input int vfp, input int vs, input int vbp,
                                                input logic hpol, input logic vpol);
        vga_preset_t p;
        p.ha   = PW'(ha);
        p.hfp  = PW'(hfp);
        p.hs   = PW'(hs);
        p.hbp  = PW'(hbp);
        p.va   = PW'(va);
        p.vfp  = PW'(vfp);
        p.vs   = PW'(vs);
        p.vbp  = PW'(vbp);
        p.hpol = hpol;
        p.vpol = vpol;
        return p;
    endfunction

    // A single-mode build still needs a 1-bit select port.
    function automatic int mode_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Every entry keeps HT and VT below 2^12 so the default 12-bit counters never overflow.
    localparam vga_preset_t P_640X480   = make_preset(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    localparam vga_preset_t P_800X600   = make_preset(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    localparam vga_preset_t P_1024X768  = make_preset(1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0);
    localparam vga_preset_t P_1280X1024 = make_preset(1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1);

    localparam vga_preset_t [15:0] VGA_PRESETS = '{
        0: P_640X480,
        1: P_800X600,
        2: P_1024X768,
        3: P_1280X1024,
        default: P_640X480
    };

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that aligns the sync/enable outputs with downstream pixel latency.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ports;
            assign unused_ports = clk ^ rst;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_mode_timing.sv
// Multi-preset VGA raster timing generator; the preset only changes on a frame boundary.
module vga_mode_timing
    import vga_pkg::*;
#(
    parameter int                  NUM_MODES = 4,
    parameter int                  CW        = 12,
    parameter int                  LAT       = 2,
    parameter vga_preset_t [15:0]  PRESETS   = VGA_PRESETS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [mode_w(NUM_MODES)-1:0]  mode_sel,
    output logic [CW-1:0]                 x,
    output logic [CW-1:0]                 y,
    output logic                          line_start,
    output logic                          frame_start,
    output logic                          de,
    output logic                          hsync,
    output logic                          vsync,
    output logic [mode_w(NUM_MODES)-1:0]  cur_mode,
    output logic                          mode_ack
);

    localparam logic [2:0] DL_RESET = {1'b0, ~PRESETS[0].hpol, ~PRESETS[0].vpol};

    vga_preset_t   p;
    logic [CW-1:0] ha, va, hs_start, hs_stop, vs_start, vs_stop, h_last, v_last;
    logic          last_x, last_y, mode_ok;
    logic          de_raw, hs_raw, vs_raw;

    assign p = PRESETS[cur_mode];

    always_comb begin
        ha       = CW'(p.ha);
        va       = CW'(p.va);
        hs_start = ha + CW'(p.hfp);
        hs_stop  = hs_start + CW'(p.hs);
        h_last   = hs_stop + CW'(p.hbp) - CW'(1);
        vs_start = va + CW'(p.vfp);
        vs_stop  = vs_start + CW'(p.vs);
        v_last   = vs_stop + CW'(p.vbp) - CW'(1);
    end

    assign last_x  = (x == h_last);
    assign last_y  = (y == v_last);
    assign mode_ok = (mode_sel != cur_mode) && (int'(mode_sel) < NUM_MODES);

    // A new preset is only taken on the last pixel of the frame so no frame is ever mixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            cur_mode <= '0;
            mode_ack <= 1'b0;
        end else begin
            mode_ack <= 1'b0;
            if (last_x) begin
                x <= '0;
                if (last_y) begin
                    y <= '0;
                    if (mode_ok) begin
                        cur_mode <= mode_sel;
                        mode_ack <= 1'b1;
                    end
                end else begin
                    y <= y + CW'(1);
                end
            end else begin
                x <= x + CW'(1);
            end
        end
    end

    // Gated by rst so the strobes stay quiet while reset holds the counters at the origin.
    assign line_start  = (x == '0) && !rst;
    assign frame_start = (x == '0) && (y == '0) && !rst;

    always_comb begin
        de_raw = (x < ha) && (y < va);
        hs_raw = ((x >= hs_start) && (x < hs_stop)) ? p.hpol : ~p.hpol;
        vs_raw = ((y >= vs_start) && (y < vs_stop)) ? p.vpol : ~p.vpol;
    end

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (LAT),
        .RESET_VAL (DL_RESET)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   ({de_raw, hs_raw, vs_raw}),
        .q   ({de, hsync, vsync})
    );

endmodule

// File: tb/tb_vga_mode_timing.sv
// Scoreboard bench for vga_mode_timing using a miniature preset table so whole frames stay short.
module tb_vga_mode_timing;
    import vga_pkg::*;

    localparam int NUM_MODES = 3;
    localparam int CW        = 12;
    localparam int LAT       = 2;
    localparam int MW        = mode_w(NUM_MODES);

    localparam vga_preset_t P0 = make_preset(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    localparam vga_preset_t P1 = make_preset(6, 2, 1, 3, 3, 1, 2, 1, 1'b1, 1'b1);
    localparam vga_preset_t P2 = make_preset(3, 1, 1, 1, 5, 1, 1, 1, 1'b1, 1'b0);
    localparam vga_preset_t P3 = make_preset(2, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    localparam vga_preset_t [15:0] TB_PRESETS = '{0: P0, 1: P1, 2: P2, 3: P3, default: P3};

    typedef struct {
        int mode;
        bit ack;
        int period;
        int ht;
        int de_cnt;
        int hs_cnt;
        int vs_cnt;
        int hs_first;
        int vs_first;
        bit hpol;
        bit vpol;
    } frame_exp_t;

    logic          clk;
    logic          rst;
    logic [MW-1:0] mode_sel;
    logic [CW-1:0] x, y;
    logic          line_start, frame_start, de, hsync, vsync, mode_ack;
    logic [MW-1:0] cur_mode;

    int checks = 0;
    int errors = 0;

    frame_exp_t sb[$];
    frame_exp_t dq[$];

    vga_mode_timing #(
        .NUM_MODES (NUM_MODES),
        .CW        (CW),
        .LAT       (LAT),
        .PRESETS   (TB_PRESETS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_sel    (mode_sel),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .cur_mode    (cur_mode),
        .mode_ack    (mode_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived per-frame figures for the three test presets.
    function automatic frame_exp_t expFrame(input int mode, input bit ack);
        frame_exp_t e;
        e.mode = mode;
        e.ack  = ack;
        case (mode)
            0:       begin e.period = 48; e.ht = 8;  e.de_cnt = 12; e.hs_cnt = 12; e.vs_cnt = 8;
                           e.hs_first = 5; e.vs_first = 32; e.hpol = 1'b0; e.vpol = 1'b0; end
            1:       begin e.period = 84; e.ht = 12; e.de_cnt = 18; e.hs_cnt = 7;  e.vs_cnt = 24;
                           e.hs_first = 8; e.vs_first = 48; e.hpol = 1'b1; e.vpol = 1'b1; end
            default: begin e.period = 48; e.ht = 6;  e.de_cnt = 15; e.hs_cnt = 8;  e.vs_cnt = 6;
                           e.hs_first = 4; e.vs_first = 36; e.hpol = 1'b1; e.vpol = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int wait_clocks, input logic [MW-1:0] sel);
        repeat (wait_clocks) @(posedge clk);
        #1 mode_sel = sel;
    endtask

    task automatic waitFrameStart(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: frame_start not seen, got timeout after %0d clocks, expected < 300", tag, n);
        end
    endtask

    frame_exp_t cur, dl_cur;
    bit  open, dl_open, line_seen;
    int  frame_cyc, line_cyc, bad_lines;
    int  off, de_cnt, hs_cnt, vs_cnt, hs_first, vs_first;
    bit  fs_hist [LAT+1];

    // Monitor: undelayed strobes are checked against frame records, the delayed outputs
    // against the same records over a window shifted by LAT clocks.
    always @(negedge clk) begin
        if (rst) begin
            open      = 1'b0;
            dl_open   = 1'b0;
            line_seen = 1'b0;
            dq.delete();
            for (int i = 0; i <= LAT; i++) fs_hist[i] = 1'b0;
        end else begin
            frame_cyc++;
            line_cyc++;
            if (line_start) begin
                if (open && line_seen && line_cyc != cur.ht) bad_lines++;
                line_cyc  = 0;
                line_seen = 1'b1;
            end
            if (frame_start) begin
                if (open) begin
                    checkOutput("frame_period", frame_cyc, cur.period);
                    checkOutput("line_period_errors", bad_lines, 0);
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: got frame_start at %0t, expected none", $time);
                    open = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    checkOutput("mode_ack", int'(mode_ack), int'(cur.ack));
                    checkOutput("cur_mode", int'(cur_mode), cur.mode);
                    dq.push_back(cur);
                    open = 1'b1;
                end
                frame_cyc = 0;
                bad_lines = 0;
            end

            for (int i = LAT; i > 0; i--) fs_hist[i] = fs_hist[i-1];
            fs_hist[0] = frame_start;
            if (fs_hist[LAT]) begin
                if (dl_open) begin
                    checkOutput("de_count", de_cnt, dl_cur.de_cnt);
                    checkOutput("hsync_count", hs_cnt, dl_cur.hs_cnt);
                    checkOutput("vsync_count", vs_cnt, dl_cur.vs_cnt);
                    checkOutput("hsync_first", hs_first, dl_cur.hs_first);
                    checkOutput("vsync_first", vs_first, dl_cur.vs_first);
                end
                if (dq.size() != 0) begin
                    dl_cur   = dq.pop_front();
                    dl_open  = 1'b1;
                    off      = 0;
                    de_cnt   = 0;
                    hs_cnt   = 0;
                    vs_cnt   = 0;
                    hs_first = -1;
                    vs_first = -1;
                end
            end
            if (dl_open) begin
                if (de) de_cnt++;
                if (hsync == dl_cur.hpol) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = off;
                end
                if (vsync == dl_cur.vpol) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = off;
                end
                off++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by %0t, expected finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        mode_sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_x", int'(x), 0);
        checkOutput("rst_y", int'(y), 0);
        checkOutput("rst_line_start", int'(line_start), 0);
        checkOutput("rst_frame_start", int'(frame_start), 0);
        checkOutput("rst_mode_ack", int'(mode_ack), 0);
        checkOutput("rst_cur_mode", int'(cur_mode), 0);
        checkOutput("rst_de", int'(de), 0);
        checkOutput("rst_hsync", int'(hsync), 1);
        checkOutput("rst_vsync", int'(vsync), 1);

        sb.push_back(expFrame(0, 1'b0));
        sb.push_back(expFrame(2, 1'b1));
        sb.push_back(expFrame(2, 1'b0));
        sb.push_back(expFrame(1, 1'b1));
        sb.push_back(expFrame(1, 1'b0));

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("release_x", int'(x), 0);
        checkOutput("release_y", int'(y), 0);
        checkOutput("release_line_start", int'(line_start), 1);
        checkOutput("release_frame_start", int'(frame_start), 1);

        applyStimulus(20, 2'd2);
        waitFrameStart("frame2");
        applyStimulus(10, 2'd3);
        waitFrameStart("frame3");
        applyStimulus(5, 2'd1);
        applyStimulus(10, 2'd3);
        applyStimulus(10, 2'd1);
        waitFrameStart("frame4");
        applyStimulus(10, 2'd0);
        applyStimulus(20, 2'd1);
        waitFrameStart("frame5");

        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        mode_sel = 2'd0;
        sb.push_back(expFrame(0, 1'b0));
        sb.push_back(expFrame(0, 1'b0));
        sb.push_back(expFrame(0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_x", int'(x), 0);
        checkOutput("midrst_y", int'(y), 0);
        checkOutput("midrst_frame_start", int'(frame_start), 1);
        checkOutput("midrst_cur_mode", int'(cur_mode), 0);
        checkOutput("midrst_de0", int'(de), 0);
        checkOutput("midrst_hsync0", int'(hsync), 1);
        @(negedge clk);
        checkOutput("midrst_de1", int'(de), 0);
        @(negedge clk);
        checkOutput("midrst_de2", int'(de), 1);

        waitFrameStart("frame7");
        waitFrameStart("frame8");
        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_mode_timing.md
VGA_MODE_TIMING -- requirements
Module: vga_mode_timing

Interface
REQ-001 Parameter NUM_MODES, default 4: number of selectable timing presets (1..16).
REQ-002 Parameter CW, default 12: width of the horizontal and vertical counters and of all timing fields.
REQ-003 Parameter LAT, default 2: pipeline delay in clocks applied to hsync, vsync and de relative to x/y (0..8).
REQ-004 clk  in  1  pixel clock; one clock domain; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mode_sel  in  $clog2(NUM_MODES)  requested preset index; level, sampled only at frame boundary.
REQ-007 x  out  CW  horizontal position; 0..HA-1 in active area, continues counting through blanking.
REQ-008 y  out  CW  vertical line number, 0..VA-1 in active area.
REQ-009 line_start  out  1  one-clock pulse when x==0 (undelayed).
REQ-010 frame_start  out  1  one-clock pulse when x==0 and y==0 (undelayed).
REQ-011 de  out  1  data enable, high when x<HA and y<VA, delayed LAT clocks.
REQ-012 hsync  out  1  horizontal sync at preset polarity, delayed LAT clocks.
REQ-013 vsync  out  1  vertical sync at preset polarity, delayed LAT clocks.
REQ-014 cur_mode  out  $clog2(NUM_MODES)  preset currently in effect.
REQ-015 mode_ack  out  1  one-clock pulse coincident with frame_start of the first frame in a newly applied mode.

Function
REQ-016 Each preset SHALL hold HA, HFP, HS, HBP, VA, VFP, VS, VBP (CW bits each), HPOL, VPOL; HT=HA+HFP+HS+HBP, VT=VA+VFP+VS+VBP.
REQ-017 Horizontal order SHALL be active, front porch, sync, back porch; hsync asserted (=HPOL) for HA+HFP <= x < HA+HFP+HS, else ~HPOL.
REQ-018 Vertical order identical; vsync asserted (=VPOL) for VA+VFP <= y < VA+VFP+VS, evaluated per line, changing at x==0.
REQ-019 x SHALL increment every clock and wrap HT-1 -> 0; y SHALL increment on each x wrap and wrap VT-1 -> 0.
REQ-020 Timing arithmetic SHALL be computed in CW bits; presets whose HT or VT exceed 2^CW-1 are illegal and excluded by the package.
REQ-021 Mode switch: on the clock where x==HT-1 and y==VT-1, if mode_sel != cur_mode and mode_sel < NUM_MODES, cur_mode SHALL load mode_sel; next clock x=y=0 under the new preset and mode_ack=1.
REQ-022 mode_sel changes mid-frame SHALL have no effect until the boundary; only the value present on the boundary clock counts.
REQ-023 mode_sel >= NUM_MODES SHALL be ignored (cur_mode held, no mode_ack).
REQ-024 mode_sel == cur_mode at boundary SHALL produce no mode_ack.
REQ-025 Delayed outputs SHALL form an LAT-stage shift register; with LAT=0 they are combinational from counters; frame-boundary polarity change propagates through the delay line unchanged (no glitch beyond one clean edge).

Reset
REQ-026 While rst=1 on a clock edge: x=0, y=0, cur_mode=0, mode_ack=0, line_start=0, frame_start=0.
REQ-027 Delay-line stages SHALL reset to de=0, hsync=~HPOL[0], vsync=~VPOL[0].
REQ-028 First clock after rst deasserts SHALL give x=0, y=0, line_start=1, frame_start=1, mode_ack=0; reset mid-frame restarts at frame origin in mode 0.

Structure
REQ-029 Shared package vga_pkg SHALL hold the preset record typedef and the preset table: 0=640x480 (640,16,96,48 / 480,10,2,33, neg/neg), 1=800x600 (800,40,128,88 / 600,1,4,23, pos/pos), 2=1024x768 (1024,24,136,160 / 768,3,6,29, neg/neg), 3=1280x1024 (1280,48,112,248 / 1024,1,3,38, pos/pos).
REQ-030 One sub-module, vga_delay_line (width, depth LAT, reset value), SHALL implement the output delay.

Verification
REQ-031 Reset, mode 0, LAT=2: hsync low for 96 clocks starting 656+2 clocks after frame_start; line period 800; frame period 420000 clocks.
REQ-032 mode_sel 0->2 at y=100: no change until frame end; next frame_start has mode_ack=1, cur_mode=2, line period 1344, hsync/vsync positive->negative handling per preset (neg).
REQ-033 mode_sel=5 with NUM_MODES=4 at boundary -> cur_mode unchanged, mode_ack=0.
REQ-034 mode_sel toggles 1->3->1 within one frame, equal to 1 at boundary -> switch to 1 only, single mode_ack.
REQ-035 rst asserted at x=500,y=300 for 1 clock -> next clock x=0,y=0, frame_start=1, de=0 for LAT clocks, cur_mode=0.
REQ-036 Mode 3: de high exactly 1280x1024 clocks per frame; vsync asserted lines 1025..1027 only.
